// File: rtl/frame_draw_sequencer.sv
// Per-frame render sequencer: snapshots the player, runs the map drawer then the tile drawer
// under per-stage watchdogs, and muxes the active engine's pixel bus onto the VGA write port.
module frame_draw_sequencer #(
  parameter int unsigned MAP_TIMEOUT  = 40000,
  parameter int unsigned TILE_TIMEOUT = 256
) (
  input  logic        CLOCK_50,
  input  logic        frame_reset,
  input  logic [7:0]  player_x,
  input  logic [7:0]  player_y,
  output logic        map_start,
  input  logic        map_done,
  input  logic        map_plot,
  input  logic [7:0]  map_x,
  input  logic [6:0]  map_y,
  input  logic [23:0] map_rgb,
  output logic        tile_start,
  output logic [7:0]  tile_x,
  output logic [7:0]  tile_y,
  input  logic        tile_done,
  input  logic        tile_plot,
  input  logic [7:0]  tile_px,
  input  logic [6:0]  tile_py,
  input  logic [23:0] tile_rgb,
  output logic        vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [23:0] vga_colour,
  output logic        frame_done,
  output logic        fault,
  output logic        dropped
);

  localparam logic [2:0] SNAP      = 3'd0;
  localparam logic [2:0] MAP_GO    = 3'd1;
  localparam logic [2:0] MAP_WAIT  = 3'd2;
  localparam logic [2:0] TILE_GO   = 3'd3;
  localparam logic [2:0] TILE_WAIT = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
  localparam logic [2:0] FAULT     = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] wd_q, wd_d;
  logic [7:0]  tile_x_q, tile_x_d;
  logic [7:0]  tile_y_q, tile_y_d;
  logic        offscreen_q, offscreen_d;
  logic        dropped_q, dropped_d;
  logic        vga_plot_q, vga_plot_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [23:0] vga_colour_q, vga_colour_d;
  logic        map_active, tile_active;
  logic [15:0] wd_inc;

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    tile_x_d     = tile_x_q;
    tile_y_d     = tile_y_q;
    offscreen_d  = offscreen_q;
    dropped_d    = dropped_q;
    vga_plot_d   = 1'b0;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    map_active   = (state_q == MAP_GO) || (state_q == MAP_WAIT);
    tile_active  = (state_q == TILE_GO) || (state_q == TILE_WAIT);
    wd_inc       = (wd_q == '1) ? wd_q : wd_q + 16'd1;

    case (state_q)
      SNAP: begin
        tile_x_d    = player_x;
        tile_y_d    = player_y;
        offscreen_d = (player_x > 8'd152) || (player_y > 8'd112);
        state_d     = MAP_GO;
      end
      MAP_GO: begin
        wd_d    = '0;
        state_d = MAP_WAIT;
      end
      MAP_WAIT: begin
        wd_d = wd_inc;
        // done is tested first so a coincident timeout loses
        if (map_done)
          state_d = offscreen_q ? DONE : TILE_GO;
        else if ({16'd0, wd_q} == MAP_TIMEOUT)
          state_d = FAULT;
      end
      TILE_GO: begin
        wd_d    = '0;
        state_d = TILE_WAIT;
      end
      TILE_WAIT: begin
        wd_d = wd_inc;
        if (tile_done)
          state_d = DONE;
        else if ({16'd0, wd_q} == TILE_TIMEOUT)
          state_d = FAULT;
      end
      DONE:    state_d = DONE;
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase

    // Outside both engine phases neither bus is forwarded, so any plot is a drop.
    if (map_active) begin
      vga_plot_d   = map_plot;
      vga_x_d      = map_x;
      vga_y_d      = map_y;
      vga_colour_d = map_rgb;
      dropped_d    = dropped_q | tile_plot;
    end else if (tile_active) begin
      vga_plot_d   = tile_plot;
      vga_x_d      = tile_px;
      vga_y_d      = tile_py;
      vga_colour_d = tile_rgb;
      dropped_d    = dropped_q | map_plot;
    end else begin
      dropped_d    = dropped_q | map_plot | tile_plot;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge frame_reset) begin
    if (frame_reset) begin
      state_q      <= SNAP;
      wd_q         <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      offscreen_q  <= 1'b0;
      dropped_q    <= 1'b0;
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      tile_x_q     <= tile_x_d;
      tile_y_q     <= tile_y_d;
      offscreen_q  <= offscreen_d;
      dropped_q    <= dropped_d;
      vga_plot_q   <= vga_plot_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
    end
  end

  assign map_start  = (state_q == MAP_GO);
  assign tile_start = (state_q == TILE_GO);
  assign frame_done = (state_q == DONE);
  assign fault      = (state_q == FAULT);
  assign dropped    = dropped_q;
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign vga_plot   = vga_plot_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;

endmodule

// File: tb/tb_frame_draw_sequencer.sv
// Bench for frame_draw_sequencer: each frame is planned as edge-indexed events
// (start pulses, done/fault edges, bus ownership windows) and checked cycle by cycle.
module tb_frame_draw_sequencer;

  localparam int MAP_TO  = 320;
  localparam int TILE_TO = 80;

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic        frame_reset = 1'b1;
  logic [7:0]  player_x = '0, player_y = '0;
  logic        map_done = 1'b0, map_plot = 1'b0;
  logic [7:0]  map_x = '0;
  logic [6:0]  map_y = '0;
  logic [23:0] map_rgb = '0;
  logic        tile_done = 1'b0, tile_plot = 1'b0;
  logic [7:0]  tile_px = '0;
  logic [6:0]  tile_py = '0;
  logic [23:0] tile_rgb = '0;
  logic        map_start, tile_start, vga_plot, frame_done, fault, dropped;
  logic [7:0]  tile_x, tile_y, vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_colour;

  frame_draw_sequencer #(.MAP_TIMEOUT(MAP_TO), .TILE_TIMEOUT(TILE_TO)) dut (
    .CLOCK_50(CLOCK_50), .frame_reset(frame_reset),
    .player_x(player_x), .player_y(player_y),
    .map_start(map_start), .map_done(map_done), .map_plot(map_plot),
    .map_x(map_x), .map_y(map_y), .map_rgb(map_rgb),
    .tile_start(tile_start), .tile_x(tile_x), .tile_y(tile_y), .tile_done(tile_done),
    .tile_plot(tile_plot), .tile_px(tile_px), .tile_py(tile_py), .tile_rgb(tile_rgb),
    .vga_plot(vga_plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .frame_done(frame_done), .fault(fault), .dropped(dropped)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Frame plan: edge 0 is the first rising edge after reset release.
  int   f_dm, f_tm, f_dt, f_tt, f_end_m, f_end_t, f_mux_edge, f_force_tile_edge;
  bit   f_map_ok, f_tile_ok, f_tile_phase, f_off, f_noisy;
  logic [7:0] f_px, f_py;

  // Expected pixel port and sticky drop flag
  logic        m_vplot, m_dropped;
  logic [7:0]  m_vx;
  logic [6:0]  m_vy;
  logic [23:0] m_vc;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit coin(input int n);
    return $urandom_range(n - 1, 0) == 0;
  endfunction

  function automatic bit map_owns(input int e);
    return (e >= 1) && (e <= f_end_m);
  endfunction

  function automatic bit tile_owns(input int e);
    return f_tile_phase && (e >= f_dm + 1) && (e <= f_end_t);
  endfunction

  function automatic bit exp_done(input int e);
    return (f_map_ok && f_off && e >= f_dm) || (f_tile_phase && f_tile_ok && e >= f_dt);
  endfunction

  function automatic bit exp_fault(input int e);
    return (!f_map_ok && e >= f_tm) || (f_tile_phase && !f_tile_ok && e >= f_tt);
  endfunction

  task automatic drive_inputs(input int e);
    if (e >= 1) begin
      player_x = 8'($urandom);
      player_y = 8'($urandom);
    end
    map_done  = (e < 2) ? (f_noisy && coin(2)) : (e >= f_dm);
    tile_done = (f_tile_phase && e >= f_dm + 2) ? (e >= f_dt) : (f_noisy && coin(2));
    map_plot  = map_owns(e)  ? coin(2) : (f_noisy && coin(64));
    tile_plot = tile_owns(e) ? coin(2) : (f_noisy && coin(64));
    map_x = 8'($urandom);  map_y = 7'($urandom);  map_rgb = 24'($urandom);
    tile_px = 8'($urandom); tile_py = 7'($urandom); tile_rgb = 24'($urandom);
    if (e == f_mux_edge) begin
      map_plot = 1'b1; map_x = 8'd5; map_y = 7'd7; map_rgb = 24'hFF0000;
      tile_plot = 1'b1;
    end
    if (e == f_force_tile_edge) tile_plot = 1'b1;
  endtask

  task automatic model_step(input int e);
    if (map_owns(e)) begin
      m_vplot = map_plot; m_vx = map_x; m_vy = map_y; m_vc = map_rgb;
      if (tile_plot) m_dropped = 1'b1;
    end else if (tile_owns(e)) begin
      m_vplot = tile_plot; m_vx = tile_px; m_vy = tile_py; m_vc = tile_rgb;
      if (map_plot) m_dropped = 1'b1;
    end else begin
      m_vplot = 1'b0;
      if (map_plot || tile_plot) m_dropped = 1'b1;
    end
  endtask

  task automatic compare(input int e);
    check_val($sformatf("ctl@%0d", e),
              64'({map_start, tile_start, frame_done, fault, dropped, vga_plot}),
              64'({e == 0, f_tile_phase && e == f_dm, exp_done(e), exp_fault(e), m_dropped, m_vplot}));
    check_val($sformatf("tile_xy@%0d", e), 64'({tile_x, tile_y}), 64'({f_px, f_py}));
    check_val($sformatf("vga@%0d", e), 64'({vga_x, vga_y, vga_colour}), 64'({m_vx, m_vy, m_vc}));
  endtask

  task automatic run_frame(input logic [7:0] px, input logic [7:0] py, input int map_lat,
                           input int tile_lat, input bit noisy, input int mux_edge,
                           input int abort_edge);
    int last;
    @(negedge CLOCK_50);
    frame_reset = 1'b1;
    map_done = 1'b0; tile_done = 1'b0; map_plot = 1'b0; tile_plot = 1'b0;
    #2;
    check_val("rst", 64'({map_start, tile_start, frame_done, fault, dropped, vga_plot,
                          tile_x, tile_y, vga_x, vga_y, vga_colour}), 64'd0);

    f_px = px; f_py = py; f_noisy = noisy;
    f_mux_edge = mux_edge; f_force_tile_edge = abort_edge;
    f_dm = 1 + map_lat;
    f_tm = 2 + MAP_TO;
    f_map_ok = (f_dm <= f_tm);
    f_end_m = f_map_ok ? f_dm : f_tm;
    f_off = (px > 8'd152) || (py > 8'd112);
    f_tile_phase = f_map_ok && !f_off;
    f_dt = f_dm + 1 + tile_lat;
    f_tt = f_dm + 2 + TILE_TO;
    f_tile_ok = (f_dt <= f_tt);
    f_end_t = f_tile_ok ? f_dt : f_tt;
    last = (f_tile_phase ? f_end_t : f_end_m) + 3;
    m_vplot = 1'b0; m_dropped = 1'b0; m_vx = '0; m_vy = '0; m_vc = '0;

    @(negedge CLOCK_50);
    frame_reset = 1'b0;
    player_x = px;
    player_y = py;
    drive_inputs(0);
    for (int e = 0; e <= last; e++) begin
      @(posedge CLOCK_50);
      #1;
      model_step(e);
      compare(e);
      if (e == abort_edge) begin
        #4 frame_reset = 1'b1;
        #1;
        check_val("abort", 64'({map_start, tile_start, frame_done, fault, dropped, vga_plot,
                                tile_x, tile_y, vga_x, vga_y, vga_colour}), 64'd0);
        return;
      end
      @(negedge CLOCK_50);
      drive_inputs(e + 1);
    end
  endtask

  initial begin
    run_frame(8'd16,  8'd24,  300, 70, 1'b0, -1, -1);             // normal frame
    run_frame(8'd160, 8'd24,  50,  10, 1'b0, -1, -1);             // off-screen x
    run_frame(8'd40,  8'd113, 20,  10, 1'b0, -1, -1);             // off-screen y, just past edge
    run_frame(8'd152, 8'd112, 20,  10, 1'b0, -1, -1);             // last on-screen position
    run_frame(8'd16,  8'd24,  1000, 10, 1'b0, -1, -1);            // map watchdog fires
    run_frame(8'd16,  8'd24,  10,  20, 1'b0, -1, -1);             // clean frame after fault
    run_frame(8'd16,  8'd24,  MAP_TO + 1, 10, 1'b0, -1, -1);      // map done meets timeout
    run_frame(8'd16,  8'd24,  30,  TILE_TO + 1, 1'b0, -1, -1);    // tile done meets timeout
    run_frame(8'd16,  8'd24,  30,  TILE_TO + 2, 1'b0, -1, -1);    // tile watchdog fires
    run_frame(8'd16,  8'd24,  10,  40, 1'b0, 5, -1);              // contended plot
    run_frame(8'd30,  8'd40,  20,  70, 1'b0, -1, 31);             // reset mid tile wait
    run_frame(8'd100, 8'd60,  15,  25, 1'b0, -1, -1);             // fresh snapshot
    for (int i = 0; i < 20; i++) begin
      run_frame(8'($urandom_range(200, 0)), 8'($urandom_range(150, 0)),
                coin(6) ? int'($urandom_range(MAP_TO + 10, MAP_TO - 5)) : int'($urandom_range(150, 1)),
                int'($urandom_range(TILE_TO + 5, 1)), coin(2), -1, -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
